// File: rtl/gcd_arbiter_ctrl_if.sv
// gcd_arbiter_ctrl_if: request/response channels between requesters and the shared GCD controller.
interface gcd_arbiter_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_gcd;
    logic [IDW-1:0]        resp_id;
    logic                  busy;

    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_gcd, resp_id, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_gcd, resp_id, busy
    );
endinterface

// File: rtl/gcd_arbiter_ctrl.sv
// gcd_arbiter_ctrl: shares one iterative subtractive GCD engine among NREQ requesters.
// Define GCD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module gcd_arbiter_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input logic clk,
    input logic reset,
    gcd_arbiter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] x, y, res;
    logic [IDW-1:0]   id, ptr, ptr_n, win, k;
    logic             found, fin;

    // Search starts at the pointer and wraps; with the pointer held at 0 this is fixed priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IDW'((int'(ptr) + i) % NREQ);
            if (!found && bus.req_valid[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
    end

`ifdef GCD_ARB_FIXED_PRIO_EN
    assign ptr_n = '0;
`else
    assign ptr_n = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif

    assign fin = (x == '0) || (y == '0) || (x == y);

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found)
            bus.req_ready[win] = 1'b1;
        state_n = state == IDLE ? (found ? RUN : IDLE) :
                  state == RUN  ? (fin ? DONE : RUN) :
                  (bus.resp_ready ? IDLE : DONE);
        bus.resp_valid = state == DONE;
        bus.resp_gcd   = res;
        bus.resp_id    = id;
        bus.busy       = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x   <= '0;
            y   <= '0;
            res <= '0;
            id  <= '0;
            ptr <= '0;
        end else if (state == IDLE && found) begin
            x   <= bus.req_x[int'(win)*WIDTH +: WIDTH];
            y   <= bus.req_y[int'(win)*WIDTH +: WIDTH];
            id  <= win;
            ptr <= ptr_n;
        end else if (state == RUN) begin
            if (x == '0)
                res <= y;
            else if (fin)
                res <= x;
            else if (x > y)
                x <= x - y;
            else
                y <= y - x;
        end
    end
endmodule

// File: tb/tb_gcd_arbiter_ctrl.sv
// tb_gcd_arbiter_ctrl: directed requests with a grant/response scoreboard for gcd_arbiter_ctrl.
module tb_gcd_arbiter_ctrl;
    typedef struct {
        int id;
        int g;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   inflight = 1'b0;
    bit   prev_v = 1'b0;
    bit   chk_busy = 1'b0;
    int   hs_cyc = 0;

    gcd_arbiter_ctrl_if #(.WIDTH(4), .NREQ(4), .IDW(2)) bus ();

    gcd_arbiter_ctrl #(.WIDTH(4), .NREQ(4), .IDW(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Monitor: pops expectations at grants, checks latency, stall stability and results.
    always @(negedge clk) begin
        if (reset) begin
            inflight = 1'b0;
            prev_v   = 1'b0;
            chk_busy = 1'b0;
        end else begin
            if (chk_busy) begin
                check("busy_after_resp", int'(bus.busy), 0);
                chk_busy = 1'b0;
            end
            if (bus.req_ready != 0) begin
                int gid = 0;
                for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gid = i;
                check("grant_onehot_and_valid", int'($onehot(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == 0)), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", gid, -1);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_id", gid, cur.id);
                    inflight = 1'b1;
                    hs_cyc   = cyc;
                end
            end
            if (bus.resp_valid) begin
                if (!inflight) begin
                    check("unexpected_resp", int'(bus.resp_gcd), -1);
                end else begin
                    if (!prev_v) check("resp_latency", cyc - hs_cyc, cur.lat);
                    if (!bus.resp_ready) begin
                        check("stall_gcd", int'(bus.resp_gcd), cur.g);
                        check("stall_id", int'(bus.resp_id), cur.id);
                        check("stall_no_grant", int'(bus.req_ready), 0);
                    end else begin
                        check("resp_gcd", int'(bus.resp_gcd), cur.g);
                        check("resp_id", int'(bus.resp_id), cur.id);
                        inflight = 1'b0;
                        chk_busy = 1'b1;
                    end
                end
            end
            prev_v = bus.resp_valid;
        end
    end

    task automatic wait_grant(input int i);
        int g = 0;
        bit hit = 1'b0;
        while (!hit && g < 200) begin
            @(negedge clk);
            hit = bus.req_valid[i] & bus.req_ready[i];
            @(posedge clk);
            #1;
            g++;
        end
        check("grant_timeout", int'(hit), 1);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic issue(input int i, input int a, input int b, input int g, input int lat);
        exp_q.push_back('{i, g, lat});
        bus.req_x[i*4 +: 4] = 4'(a);
        bus.req_y[i*4 +: 4] = 4'(b);
        bus.req_valid[i]    = 1'b1;
        wait_grant(i);
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(posedge clk);
            #2;
            g++;
        end while ((inflight || bus.busy || exp_q.size() != 0) && g < 400);
        check("idle_timeout", int'(g < 400), 1);
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_resp_valid"}, int'(bus.resp_valid), 0);
        check({nm, "_busy"}, int'(bus.busy), 0);
        check({nm, "_req_ready"}, int'(bus.req_ready), 0);
        check({nm, "_gcd"}, int'(bus.resp_gcd), 0);
        check({nm, "_id"}, int'(bus.resp_id), 0);
    endtask

    initial begin
        int n;
        int guard;
        logic [3:0] hs;
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // (12,8): (4,8) -> (4,4), two steps
        issue(2, 12, 8, 4, 4);
        wait_idle();

        issue(3, 0, 0, 0, 2);
        wait_idle();
        issue(3, 0, 9, 9, 2);
        wait_idle();
        issue(3, 7, 0, 7, 2);
        wait_idle();
        issue(3, 5, 5, 5, 2);
        wait_idle();

        // Four contenders; requester 0 keeps re-requesting until four grants have gone by.
`ifdef GCD_ARB_FIXED_PRIO_EN
        repeat (4) exp_q.push_back('{0, 1, 16});
`else
        exp_q.push_back('{0, 1, 16});
`endif
        exp_q.push_back('{1, 3, 4});
        exp_q.push_back('{2, 4, 3});
        exp_q.push_back('{3, 3, 2});
        bus.req_x     = {4'd3, 4'd8, 4'd9, 4'd15};
        bus.req_y     = {4'd3, 4'd4, 4'd6, 4'd1};
        bus.req_valid = 4'hf;
        n     = 0;
        guard = 0;
        while (bus.req_valid != 0 && guard < 2000) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            guard++;
            if (hs != 0) begin
                n++;
                bus.req_valid = bus.req_valid & ~(hs & 4'b1110);
                if (n >= 4) bus.req_valid[0] = 1'b0;
            end
        end
        check("arb_phase_timeout", int'(guard < 2000), 1);
        wait_idle();

        // Backpressure on (10,4) while requester 0 waits for the engine.
        bus.resp_ready = 1'b0;
        issue(1, 10, 4, 2, 5);
        exp_q.push_back('{0, 2, 4});
        bus.req_x[3:0] = 4'd4;
        bus.req_y[3:0] = 4'd6;
        bus.req_valid[0] = 1'b1;
        guard = 0;
        while (!bus.resp_valid && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("bp_resp_timeout", int'(guard < 100), 1);
        repeat (5) @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        wait_grant(0);
        wait_idle();

        // Abort a long (15,1) run with reset; it must never respond.
        exp_q.push_back('{1, 1, 16});
        bus.req_x[7:4] = 4'd15;
        bus.req_y[7:4] = 4'd1;
        bus.req_valid[1] = 1'b1;
        wait_grant(1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        repeat (20) @(posedge clk);
        #1;
        issue(2, 6, 9, 3, 4);
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
